tff_count_ctrl: RTL and testbench
=================================

# tff_count_ctrl

Sequencer for a WIDTH-bit bank of `t_ff` toggle flip-flops that turns the bank into a start/stop-controlled modulo counter. It counts up or down between 0 and a programmable limit, in continuous or one-shot mode. A small FSM computes the per-bit toggle enables each cycle from the current bank outputs. The block sits between control logic (start/stop pulses) and the `t_ff` bank it owns, and exposes the bank value as `count`.

## Interface
- `WIDTH`, default 4: number of `t_ff` cells in the bank, and the width of `limit` and `count`.

- `clk`  in  1  rising-edge clock for the FSM and all `t_ff` cells.
- `reset`  in  1  asynchronous, active-high; clears the FSM and every `t_ff` cell.
- `start`  in  1  launches a run; honoured only in IDLE.
- `stop`  in  1  aborts a run; honoured only in RUN.
- `dir`  in  1  1 = up, 0 = down; sampled when `start` is accepted.
- `one_shot`  in  1  1 = stop at terminal value, 0 = wrap forever; sampled when `start` is accepted.
- `limit`  in  WIDTH  modulo limit; sampled when `start` is accepted.
- `count`  out  WIDTH  `q` outputs of the `t_ff` bank.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse while in DONE.
- `wrap`  out  1  one-cycle pulse after each wrap-around in continuous mode.

## Operation
- Bank structure: one `t_ff` per bit; bit i receives `t_vec[i]`. Internally, `t_vec = count ^ next_count`.
- Next-value rules:
  - count is never loaded directly, only toggled;
  - all arithmetic is modulo 2^WIDTH;
  - `limit` is unsigned.
- Registered configuration: `lim_r`, `dir_r`, `os_r` are captured on `start` acceptance.
- Terminal value: `lim_r` when up, 0 when down.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `t_vec` = 0; count holds.
  - On `start`: load start value, capture configuration, go to RUN.
  - Start value is 0 when `dir`=1 and `limit` when `dir`=0.
  - `stop` is ignored. If `start` and `stop` are both high, `start` wins.
- RUN, evaluated in priority order:
  1. `stop`=1: `t_vec`=0, go to IDLE, count holds.
  2. Count equals terminal and `os_r`=1: `t_vec`=0, go to DONE.
  3. Count equals terminal and `os_r`=0:
     - up: next = 0; down: next = `lim_r`;
     - `wrap` is set for the following cycle.
  4. Otherwise: next = count+1 (up) or count−1 (down).
  - `start` is ignored in RUN.
- DONE: `t_vec`=0; count holds at terminal; unconditionally return to IDLE. `start` is ignored.
- `limit`=0:
  - The terminal value equals the start value.
  - Continuous mode: count stays 0, `t_vec`=0, and `wrap` pulses every RUN cycle after the first.
  - One-shot mode: one RUN cycle, then DONE.
- Count out of range: if count > `lim_r` (not reachable in normal operation), up-count still increments and wraps modulo 2^WIDTH until it hits `lim_r`. No special handling.
- Reset mid-operation: FSM returns to IDLE, count = 0, and `busy`/`done`/`wrap` = 0 immediately (asynchronously).

## Timing
- Reset values: `count`=0, `busy`=0, `done`=0, `wrap`=0; state = IDLE.
- Output derivation: `busy` and `done` are decoded from the state register; `wrap` is a registered flag. Outputs have no combinational path from inputs.
- Start latency: `start` seen at edge k gives state RUN and count = start value after edge k. The first advance happens at edge k+1.
- One-shot run length: up from 0 to L takes L+1 RUN cycles. DONE is entered at edge k+L+1; `done` is high for exactly the cycle after that edge; IDLE is entered at edge k+L+2.
- Continuous period: L+1 cycles per full sequence. `wrap` is high in the cycle after the edge that performs the terminal→start transition.
- Stop latency: `stop` at edge m gives `busy`=0 after edge m, with count frozen at its pre-edge value.
- Back-to-back runs: a new `start` is accepted at the first edge in IDLE, two edges after DONE is entered.

## Test plan
- Reset with `start` held high → `count`=0, `busy`=0 throughout. After release, the first edge with `start` moves the FSM to RUN.
- WIDTH=4, one-shot up, `limit`=3 → `count` 0,1,2,3 over 4 `busy` cycles; then `done`=1 for one cycle with `count`=3; then IDLE.
- Continuous down, `limit`=5 → `count` 5,4,3,2,1,0,5,4…; `wrap`=1 only in the cycle showing the first 5 after each 0.
- Continuous up, `limit`=15 (WIDTH=4) → 0…15,0 with `wrap` pulse; `stop` asserted while `count`=9 → `count` holds 9, `busy`=0 the next cycle, no `done`.
- `limit`=0, one-shot → one `busy` cycle with `count`=0, then a `done` pulse. `start` during RUN/DONE has no effect, and the configuration stays unchanged.
- Async `reset` pulse mid-run at `count`=6 (not on a clock edge) → `count`=0, `busy`=0 immediately; the block stays idle until a fresh `start`.

Source files
------------

// File: rtl/tff_count_ctrl.sv
// Start/stop modulo counter built from a bank of toggle flip-flops.
// A three-state sequencer derives the per-bit toggle enables from the current bank value.

module t_ff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end
endmodule

module tff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] lim_r;
    logic             dir_r, os_r;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] t_vec;
    logic             cap;
    logic             wrap_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Run configuration is only meaningful once a start has been accepted.
    always_ff @(posedge clk) begin
        if (cap) begin
            lim_r <= limit;
            dir_r <= dir;
            os_r  <= one_shot;
        end
    end

    always_comb begin
        state_nxt  = state;
        next_count = count;
        cap        = 1'b0;
        wrap_nxt   = 1'b0;
        term       = dir_r ? lim_r : '0;
        case (state)
            IDLE: begin
                if (start) begin
                    cap        = 1'b1;
                    state_nxt  = RUN;
                    next_count = dir ? '0 : limit;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (count == term) begin
                    if (os_r) begin
                        state_nxt = DONE;
                    end else begin
                        next_count = dir_r ? '0 : lim_r;
                        wrap_nxt   = 1'b1;
                    end
                end else begin
                    next_count = dir_r ? count + WIDTH'(1) : count - WIDTH'(1);
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // The bank can only toggle, so any new value is expressed as a bit difference.
        t_vec = count ^ next_count;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        t_ff u_tff (
            .clk  (clk),
            .reset(reset),
            .t    (t_vec[i]),
            .q    (count[i])
        );
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_tff_count_ctrl.sv
// Randomised scoreboard bench for tff_count_ctrl: a run-level model queues the expected
// outputs for every clock edge and a separate monitor compares them against the DUT.

module tb_tff_count_ctrl;
    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic             stop;
    logic             dir;
    logic             one_shot;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             wrap;

    tff_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .dir     (dir),
        .one_shot(one_shot),
        .limit   (limit),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {count, busy, done, wrap}
    logic [WIDTH+2:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Run-level model: a run is an index n into the arithmetic sequence of the captured configuration.
    int   m_phase;   // 0 idle, 1 running, 2 finished
    int   m_n;
    int   m_lim;
    logic m_dir;
    logic m_os;
    logic [WIDTH-1:0] m_cnt;

    function automatic logic [WIDTH-1:0] seq_val(input int k);
        int r;
        r = k % (m_lim + 1);
        return m_dir ? WIDTH'(r) : WIDTH'(m_lim - r);
    endfunction

    initial begin
        logic e_wrap;
        m_phase = 0;
        m_n     = 0;
        m_lim   = 0;
        m_dir   = 1'b1;
        m_os    = 1'b0;
        m_cnt   = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_phase = 0;
                m_cnt   = '0;
            end else begin
                e_wrap = 1'b0;
                case (m_phase)
                    0: if (start) begin
                        m_phase = 1;
                        m_dir   = dir;
                        m_os    = one_shot;
                        m_lim   = int'(limit);
                        m_n     = 0;
                        m_cnt   = seq_val(0);
                    end
                    1: begin
                        if (stop)
                            m_phase = 0;
                        else if (m_os && m_n == m_lim)
                            m_phase = 2;
                        else begin
                            m_n    = m_n + 1;
                            m_cnt  = seq_val(m_n);
                            e_wrap = !m_os && (m_n % (m_lim + 1) == 0);
                        end
                    end
                    default: m_phase = 0;
                endcase
                exp_q.push_back({m_cnt, m_phase == 1, m_phase == 2, e_wrap});
            end
        end
    end

    // Monitor: outputs must be zero while reset is high, otherwise match the queued expectation.
    initial begin
        logic [WIDTH+2:0] got, want;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            got = {count, busy, done, wrap};
            if (reset) begin
                want = '0;
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL reset_outputs t=%0t count/busy/done/wrap got %h/%b/%b/%b want 0/0/0/0",
                             $time, got[WIDTH+2:3], got[2], got[1], got[0]);
                end
            end else if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t got %h want an expected entry", $time, got);
            end else begin
                want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL cycle_outputs t=%0t count/busy/done/wrap got %h/%b/%b/%b want %h/%b/%b/%b",
                             $time, got[WIDTH+2:3], got[2], got[1], got[0],
                             want[WIDTH+2:3], want[2], want[1], want[0]);
                end
            end
        end
    end

    task automatic drive(input logic s, input logic p, input logic d, input logic o,
                         input logic [WIDTH-1:0] l);
        @(negedge clk);
        start    = s;
        stop     = p;
        dir      = d;
        one_shot = o;
        limit    = l;
    endtask

    // Idle cycles scramble the configuration inputs, which must not affect a captured run.
    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            drive(1'b0, 1'b0, 1'($urandom), 1'($urandom), WIDTH'($urandom));
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b1;
        stop     = 1'b0;
        dir      = 1'b1;
        one_shot = 1'b1;
        limit    = 4'd2;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(6);

        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
        idle(7);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        idle(14);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
        idle(2);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd15);
        idle(25);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd15);
        idle(3);

        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
        idle(3);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        idle(4);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        idle(1);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd10);
        idle(6);
        @(negedge clk);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        idle(4);

        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  1'($urandom), 1'($urandom), WIDTH'($urandom));
        idle(3);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
